acq_frame_scheduler: RTL and testbench

Frame sequencer for the CCD/ADC acquisition core. After each release from reset, the acquisition core runs exactly one reset/integration/readout cycle (1024 pixels into the write FIFO) and then parks. This block issues a fresh active-low restart for each frame, watches the core's frame and send flags, and waits for the downstream FIFO to drain. It then spaces frames by a programmable period. It sits between the top level (mode and period settings) and the acquisition core plus its FIFO.

---
 rtl/acq_frame_scheduler.sv | 135 +++++++++++++
 tb/tb_acq_frame_scheduler.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/acq_frame_scheduler.sv
// rtl/acq_frame_scheduler.sv - frame sequencer driving the acquisition core restart
// Arms the core once per frame, tracks its send flag and FIFO drain, then spaces frames.
module acq_frame_scheduler #(
  parameter int RST_HOLD = 4,
  parameter int TIMEOUT  = 200000,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             single,
  input  logic [23:0]      period,
  input  logic             err_clr,
  output logic             acq_rst_n,
  input  logic             acq_frameclk,
  input  logic             acq_sending,
  input  logic             fifo_rdempty,
  output logic             busy,
  output logic             frame_done,
  output logic [CNT_W-1:0] frame_cnt,
  output logic             timeout_err
);

  localparam int HOLD_W = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;
  localparam int TO_W   = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_HOLD - 1);
  localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE, ARM, START, RUN, DRAIN, GAP, ABORT
  } state_t;

  state_t             state;
  state_t             state_next;
  logic [HOLD_W-1:0]  hold_cnt;
  logic [23:0]        period_cnt;
  logic [TO_W-1:0]    timeout_cnt;
  logic               frameclk_q;
  logic               sending_q;
  logic               sending_prev;
  logic               rdempty_q;

  // The frame flag is sampled alongside the others but never qualifies a transition.
  logic frameclk_unused;
  assign frameclk_unused = frameclk_q;

  logic sending_rise;
  logic sending_fall;
  logic to_expired;
  logic period_ok;
  logic watched;
  logic watched_next;

  assign sending_rise = sending_q & ~sending_prev;
  assign sending_fall = ~sending_q & sending_prev;
  assign to_expired   = (timeout_cnt == TO_LAST);
  assign period_ok    = (period == 24'd0) || (period_cnt >= (period - 24'd1));
  assign watched      = (state == START) || (state == RUN) || (state == DRAIN);
  assign watched_next = (state_next == START) || (state_next == RUN) || (state_next == DRAIN);

  always_comb begin
    state_next = state;
    case (state)
      IDLE:  if (enable || single) state_next = ARM;
      ARM:   if (hold_cnt == HOLD_LAST) state_next = START;
      START: begin
        if (to_expired)        state_next = ABORT;
        else if (sending_rise) state_next = RUN;
      end
      RUN: begin
        if (to_expired)        state_next = ABORT;
        else if (sending_fall) state_next = DRAIN;
      end
      DRAIN: begin
        if (to_expired)        state_next = ABORT;
        else if (rdempty_q)    state_next = GAP;
      end
      GAP: begin
        if (!enable)           state_next = IDLE;
        else if (period_ok)    state_next = ARM;
      end
      ABORT:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      hold_cnt     <= '0;
      period_cnt   <= '0;
      timeout_cnt  <= '0;
      frameclk_q   <= 1'b0;
      sending_q    <= 1'b0;
      sending_prev <= 1'b0;
      rdempty_q    <= 1'b0;
      acq_rst_n    <= 1'b0;
      busy         <= 1'b0;
      frame_done   <= 1'b0;
      frame_cnt    <= '0;
      timeout_err  <= 1'b0;
    end else begin
      frameclk_q   <= acq_frameclk;
      sending_q    <= acq_sending;
      sending_prev <= sending_q;
      rdempty_q    <= fifo_rdempty;
      state        <= state_next;

      hold_cnt <= (state == ARM) ? hold_cnt + 1'b1 : '0;

      // Held at zero through ARM so frame spacing is measured from the restart release.
      if (state == ARM)
        period_cnt <= '0;
      else if (period_cnt != '1)
        period_cnt <= period_cnt + 24'd1;

      if (watched_next && (state_next != state))
        timeout_cnt <= '0;
      else if (watched)
        timeout_cnt <= timeout_cnt + 1'b1;

      acq_rst_n  <= watched_next;
      busy       <= (state_next != IDLE);
      frame_done <= (state == DRAIN) && (state_next == GAP);
      if ((state == DRAIN) && (state_next == GAP))
        frame_cnt <= frame_cnt + 1'b1;

      if (state_next == ABORT)
        timeout_err <= 1'b1;
      else if (err_clr)
        timeout_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_acq_frame_scheduler.sv
// tb/tb_acq_frame_scheduler.sv - randomized bench for acq_frame_scheduler
// A core/FIFO model reacts to acq_rst_n; event timestamps are checked against frame rules.
module tb_acq_frame_scheduler;

  localparam int RST_HOLD = 4;
  localparam int TIMEOUT  = 2000;
  localparam int CNT_W    = 2;
  localparam int CNT_MOD  = 1 << CNT_W;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              enable = 1'b0;
  logic              single = 1'b0;
  logic [23:0]       period = 24'd0;
  logic              err_clr = 1'b0;
  logic              acq_rst_n;
  logic              acq_frameclk = 1'b0;
  logic              acq_sending = 1'b0;
  logic              fifo_rdempty = 1'b1;
  logic              busy;
  logic              frame_done;
  logic [CNT_W-1:0]  frame_cnt;
  logic              timeout_err;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int exp_frames = 0;

  int rise_q[$];
  int fall_q[$];
  int done_q[$];
  int cnt_q[$];
  int err_q[$];
  int empty_q[$];

  int core_ph = 0;
  int core_n = 0;
  int pre_len = 2;
  int send_len = 200;
  int drain_len = 0;
  int send_lo = 200;
  int send_hi = 600;
  int drain_lo = 0;
  int drain_hi = 300;
  bit core_silent = 1'b0;

  logic prev_rstn = 1'b0;
  logic prev_err = 1'b0;

  acq_frame_scheduler #(.RST_HOLD(RST_HOLD), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .enable(enable), .single(single), .period(period),
    .err_clr(err_clr), .acq_rst_n(acq_rst_n), .acq_frameclk(acq_frameclk),
    .acq_sending(acq_sending), .fifo_rdempty(fifo_rdempty), .busy(busy),
    .frame_done(frame_done), .frame_cnt(frame_cnt), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  // Event monitor: timestamps are edge indices, sampled just after the edge.
  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      if (acq_rst_n === 1'b1 && prev_rstn !== 1'b1) rise_q.push_back(cyc);
      if (acq_rst_n === 1'b0 && prev_rstn === 1'b1) fall_q.push_back(cyc);
      if (frame_done === 1'b1) begin
        done_q.push_back(cyc);
        cnt_q.push_back(int'(frame_cnt));
      end
      if (timeout_err === 1'b1 && prev_err !== 1'b1) err_q.push_back(cyc);
      prev_rstn = acq_rst_n;
      prev_err  = timeout_err;
    end
  end

  // Acquisition core plus FIFO: one frame per restart release, then parks.
  always @(negedge clk) begin
    if (acq_rst_n !== 1'b1) begin
      core_ph = 0; core_n = 0;
      acq_frameclk = 1'b0; acq_sending = 1'b0; fifo_rdempty = 1'b1;
    end else begin
      case (core_ph)
        0: begin
          acq_frameclk = 1'b1; core_ph = 1; core_n = 0;
          pre_len   = int'($urandom_range(20, 2));
          send_len  = int'($urandom_range(send_hi, send_lo));
          drain_len = int'($urandom_range(drain_hi, drain_lo));
        end
        1: if (!core_silent) begin
          if (core_n >= pre_len) begin
            acq_frameclk = 1'b0; acq_sending = 1'b1; fifo_rdempty = 1'b0;
            core_ph = 2; core_n = 0;
          end else core_n++;
        end
        2: if (core_n >= send_len) begin
          acq_sending = 1'b0; core_ph = 3; core_n = 0;
        end else core_n++;
        3: if (core_n >= drain_len) begin
          fifo_rdempty = 1'b1; empty_q.push_back(cyc); core_ph = 4;
        end else core_n++;
        default: ;
      endcase
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_log();
    rise_q.delete(); fall_q.delete(); done_q.delete();
    cnt_q.delete(); err_q.delete(); empty_q.delete();
  endtask

  task automatic wait_idle(input int limit, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (busy === 1'b0) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_dones(input int n, input int limit, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (done_q.size() >= n) begin ok = 1'b1; break; end
    end
  endtask

  function automatic int qget(input int q[$], input int i);
    return (i < q.size()) ? q[i] : -1;
  endfunction

  task automatic test_reset();
    rst = 1'b1; enable = 1'b0; single = 1'b0; period = 24'd0; err_clr = 1'b0;
    tick(3);
    total++; if (acq_rst_n !== 1'b0) begin bad++; $display("FAIL reset_acq_rst_n got=%b exp=0", acq_rst_n); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    total++; if (frame_done !== 1'b0) begin bad++; $display("FAIL reset_frame_done got=%b exp=0", frame_done); end
    total++; if (frame_cnt !== '0) begin bad++; $display("FAIL reset_frame_cnt got=%0d exp=0", frame_cnt); end
    total++; if (timeout_err !== 1'b0) begin bad++; $display("FAIL reset_timeout_err got=%b exp=0", timeout_err); end
    rst = 1'b0;
    tick(3);
    total++; if (busy !== 1'b0 || acq_rst_n !== 1'b0) begin bad++; $display("FAIL idle_after_reset got=%b%b exp=00", busy, acq_rst_n); end
    exp_frames = 0;
  endtask

  task automatic test_single();
    int t0;
    bit ok;
    clear_log();
    send_lo = 200; send_hi = 600; drain_lo = 0; drain_hi = 300;
    t0 = cyc;
    single = 1'b1; tick(1); single = 1'b0;
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL single_busy_rise got=%b exp=1", busy); end
    wait_idle(3000, ok);
    exp_frames++;
    total++; if (ok !== 1'b1) begin bad++; $display("FAIL single_idle_timeout got=%b exp=1", ok); end
    total++; if (qget(rise_q, 0) != t0 + RST_HOLD + 1) begin bad++; $display("FAIL single_release got=%0d exp=%0d", qget(rise_q, 0), t0 + RST_HOLD + 1); end
    total++; if (done_q.size() != 1) begin bad++; $display("FAIL single_done_count got=%0d exp=1", done_q.size()); end
    total++; if (qget(done_q, 0) != qget(empty_q, 0) + 2) begin bad++; $display("FAIL single_done_time got=%0d exp=%0d", qget(done_q, 0), qget(empty_q, 0) + 2); end
    total++; if (qget(fall_q, 0) != qget(done_q, 0)) begin bad++; $display("FAIL single_restart_fall got=%0d exp=%0d", qget(fall_q, 0), qget(done_q, 0)); end
    total++; if (int'(frame_cnt) != exp_frames % CNT_MOD) begin bad++; $display("FAIL single_frame_cnt got=%0d exp=%0d", frame_cnt, exp_frames % CNT_MOD); end
    total++; if (acq_rst_n !== 1'b0) begin bad++; $display("FAIL single_parked got=%b exp=0", acq_rst_n); end
  endtask

  task automatic test_continuous();
    int t0;
    int base;
    int p;
    bit ok;
    clear_log();
    p = 1500; period = 24'(p);
    send_lo = 300; send_hi = 600; drain_lo = 0; drain_hi = 300;
    base = exp_frames;
    t0 = cyc;
    enable = 1'b1;
    wait_dones(3, 8000, ok);
    enable = 1'b0;
    total++; if (ok !== 1'b1) begin bad++; $display("FAIL cont_done_timeout got=%b exp=1", ok); end
    wait_idle(3000, ok);
    exp_frames += 3;
    total++; if (rise_q.size() != 3) begin bad++; $display("FAIL cont_frames got=%0d exp=3", rise_q.size()); end
    total++; if (qget(rise_q, 0) != t0 + RST_HOLD + 1) begin bad++; $display("FAIL cont_first_release got=%0d exp=%0d", qget(rise_q, 0), t0 + RST_HOLD + 1); end
    for (int i = 1; i < 3; i++) begin
      total++; if (qget(rise_q, i) - qget(rise_q, i - 1) != p + RST_HOLD) begin bad++; $display("FAIL cont_spacing%0d got=%0d exp=%0d", i, qget(rise_q, i) - qget(rise_q, i - 1), p + RST_HOLD); end
    end
    for (int i = 0; i < 3; i++) begin
      total++; if (qget(done_q, i) != qget(empty_q, i) + 2) begin bad++; $display("FAIL cont_done_time%0d got=%0d exp=%0d", i, qget(done_q, i), qget(empty_q, i) + 2); end
      total++; if (qget(cnt_q, i) != (base + i + 1) % CNT_MOD) begin bad++; $display("FAIL cont_cnt%0d got=%0d exp=%0d", i, qget(cnt_q, i), (base + i + 1) % CNT_MOD); end
    end
  endtask

  task automatic test_back_to_back();
    int base;
    bit ok;
    clear_log();
    period = 24'd0;
    send_lo = 100; send_hi = 400; drain_lo = 0; drain_hi = 50;
    base = exp_frames;
    enable = 1'b1;
    wait_dones(3, 6000, ok);
    enable = 1'b0;
    total++; if (ok !== 1'b1) begin bad++; $display("FAIL b2b_done_timeout got=%b exp=1", ok); end
    wait_idle(3000, ok);
    exp_frames += 3;
    for (int i = 1; i < 3; i++) begin
      total++; if (qget(fall_q, i - 1) != qget(done_q, i - 1)) begin bad++; $display("FAIL b2b_fall%0d got=%0d exp=%0d", i, qget(fall_q, i - 1), qget(done_q, i - 1)); end
      total++; if (qget(rise_q, i) - qget(done_q, i - 1) != RST_HOLD + 1) begin bad++; $display("FAIL b2b_low_width%0d got=%0d exp=%0d", i, qget(rise_q, i) - qget(done_q, i - 1), RST_HOLD + 1); end
    end
    for (int i = 0; i < 3; i++) begin
      total++; if (qget(cnt_q, i) != (base + i + 1) % CNT_MOD) begin bad++; $display("FAIL b2b_cnt%0d got=%0d exp=%0d", i, qget(cnt_q, i), (base + i + 1) % CNT_MOD); end
    end
  endtask

  task automatic test_drain_hold();
    bit ok;
    clear_log();
    send_lo = 200; send_hi = 300; drain_lo = 1500; drain_hi = 1500;
    single = 1'b1; tick(1); single = 1'b0;
    for (int i = 0; i < 2000 && core_ph != 3; i++) tick(1);
    tick(100);
    single = 1'b1; tick(1); single = 1'b0;
    wait_idle(4000, ok);
    exp_frames++;
    total++; if (ok !== 1'b1) begin bad++; $display("FAIL drain_idle_timeout got=%b exp=1", ok); end
    total++; if (done_q.size() != 1) begin bad++; $display("FAIL drain_done_count got=%0d exp=1", done_q.size()); end
    total++; if (qget(done_q, 0) != qget(empty_q, 0) + 2) begin bad++; $display("FAIL drain_done_time got=%0d exp=%0d", qget(done_q, 0), qget(empty_q, 0) + 2); end
    tick(20);
    total++; if (rise_q.size() != 1) begin bad++; $display("FAIL drain_single_ignored got=%0d exp=1", rise_q.size()); end
    total++; if (int'(frame_cnt) != exp_frames % CNT_MOD) begin bad++; $display("FAIL drain_frame_cnt got=%0d exp=%0d", frame_cnt, exp_frames % CNT_MOD); end
  endtask

  task automatic test_timeout();
    bit ok;
    clear_log();
    core_silent = 1'b1;
    single = 1'b1; tick(1); single = 1'b0;
    wait_idle(TIMEOUT + 200, ok);
    core_silent = 1'b0;
    total++; if (ok !== 1'b1) begin bad++; $display("FAIL timeout_idle got=%b exp=1", ok); end
    total++; if (qget(err_q, 0) != qget(rise_q, 0) + TIMEOUT) begin bad++; $display("FAIL timeout_abort_time got=%0d exp=%0d", qget(err_q, 0), qget(rise_q, 0) + TIMEOUT); end
    total++; if (timeout_err !== 1'b1) begin bad++; $display("FAIL timeout_err_set got=%b exp=1", timeout_err); end
    total++; if (done_q.size() != 0) begin bad++; $display("FAIL timeout_no_done got=%0d exp=0", done_q.size()); end
    total++; if (int'(frame_cnt) != exp_frames % CNT_MOD) begin bad++; $display("FAIL timeout_frame_cnt got=%0d exp=%0d", frame_cnt, exp_frames % CNT_MOD); end
    err_clr = 1'b1; tick(1); err_clr = 1'b0; tick(1);
    total++; if (timeout_err !== 1'b0) begin bad++; $display("FAIL timeout_err_clr got=%b exp=0", timeout_err); end
  endtask

  task automatic test_wrap_and_reset();
    int exp_seq [5];
    bit ok;
    exp_seq = '{1, 2, 3, 0, 1};
    rst = 1'b1; tick(2); rst = 1'b0; tick(2);
    exp_frames = 0;
    clear_log();
    period = 24'd0;
    send_lo = 100; send_hi = 300; drain_lo = 0; drain_hi = 100;
    enable = 1'b1;
    wait_dones(5, 9000, ok);
    enable = 1'b0;
    wait_idle(3000, ok);
    for (int i = 0; i < 5; i++) begin
      total++; if (qget(cnt_q, i) != exp_seq[i]) begin bad++; $display("FAIL wrap_cnt%0d got=%0d exp=%0d", i, qget(cnt_q, i), exp_seq[i]); end
    end
    single = 1'b1; tick(1); single = 1'b0;
    for (int i = 0; i < 500 && core_ph != 2; i++) tick(1);
    tick(10);
    total++; if (acq_rst_n !== 1'b1 || busy !== 1'b1) begin bad++; $display("FAIL run_before_reset got=%b%b exp=11", acq_rst_n, busy); end
    rst = 1'b1; tick(1);
    total++; if (acq_rst_n !== 1'b0) begin bad++; $display("FAIL midrst_acq_rst_n got=%b exp=0", acq_rst_n); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL midrst_busy got=%b exp=0", busy); end
    total++; if (frame_done !== 1'b0) begin bad++; $display("FAIL midrst_frame_done got=%b exp=0", frame_done); end
    total++; if (frame_cnt !== '0) begin bad++; $display("FAIL midrst_frame_cnt got=%0d exp=0", frame_cnt); end
    total++; if (timeout_err !== 1'b0) begin bad++; $display("FAIL midrst_timeout_err got=%b exp=0", timeout_err); end
    rst = 1'b0; tick(3);
  endtask

  initial begin
    test_reset();
    test_single();
    test_continuous();
    test_back_to_back();
    test_drain_hold();
    test_timeout();
    test_wrap_and_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
